pwm_phase_gen: RTL and testbench

Generates the raw complementary gate-control pair for one inverter half-bridge: a free-running PWM counter, a duty compare, and a drive-mode select. Its outputs feed the dead-time insertion stage that sits between this block and the FETs.
- This block never asserts high and low together.
- It does not insert dead time; that is the downstream stage's job.
- pwm_sync marks each period start so the current-sense ADC can align to the PWM.

---
 rtl/pwm_phase_gen.sv | 127 ++++++++++++
 tb/tb_pwm_phase_gen.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_phase_gen.sv
// pwm_phase_gen
// Raw complementary gate-request generator for one inverter half-bridge.
// A free-running counter is compared against a shadowed duty value, and a
// shadowed drive mode selects drive / brake / coast. Duty and mode are only
// taken at period boundaries, so a period is never torn by a mid-period
// update. Dead time is not inserted here; the downstream stage handles it.
// high_ctrl and low_ctrl are never requested together.
module pwm_phase_gen #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] duty,
  input  logic [1:0]       mode,
  output logic             high_ctrl,
  output logic             low_ctrl,
  output logic             pwm_sync
);

  localparam logic [WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO   = '0;
  localparam logic [1:0]       MODE_COAST = 2'b00;
  localparam logic [1:0]       MODE_DRIVE = 2'b01;
  localparam logic [1:0]       MODE_BRAKE = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic [1:0]       mode_sh_q, mode_sh_d;
  logic             high_q, high_d;
  logic             low_q, low_d;
  logic             sync_q, sync_d;
  logic             pwm_on;

  // Unsigned full-width compare on the pre-increment count. duty = max
  // leaves one off clock per period, which keeps the bootstrap refreshed.
  assign pwm_on = (cnt_q < duty_sh_q);

  // State, counter, shadows and output flops; reset drops the FET requests
  // immediately, without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      duty_sh_q <= CNT_ZERO;
      mode_sh_q <= MODE_COAST;
      high_q    <= 1'b0;
      low_q     <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      duty_sh_q <= duty_sh_d;
      mode_sh_q <= mode_sh_d;
      high_q    <= high_d;
      low_q     <= low_d;
      sync_q    <= sync_d;
    end
  end

  // Next-state and next-output logic. Outputs default to coast so that any
  // path not explicitly driving (stop, start edge, coast modes) is safe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    duty_sh_d = duty_sh_q;
    mode_sh_d = mode_sh_q;
    high_d    = 1'b0;
    low_d     = 1'b0;
    sync_d    = 1'b0;

    if (!en) begin
      // Stop wins over everything, including brake: coast and rewind.
      // Shadows are kept but will be reloaded on the next start.
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Fresh start: there is no resume of an interrupted period.
          state_d   = ST_RUN;
          cnt_d     = CNT_ZERO;
          duty_sh_d = duty;
          mode_sh_d = mode;
        end
        ST_RUN: begin
          cnt_d = cnt_q + WIDTH'(1);
          if (cnt_q == CNT_MAX) begin
            // Last clock of the period: new settings apply from the next one.
            duty_sh_d = duty;
            mode_sh_d = mode;
          end
          sync_d = (cnt_q == CNT_ZERO);
          case (mode_sh_q)
            MODE_DRIVE: begin
              high_d = pwm_on;
              low_d  = ~pwm_on;
            end
            MODE_BRAKE: begin
              high_d = 1'b0;
              low_d  = 1'b1;
            end
            default: begin
              high_d = 1'b0;
              low_d  = 1'b0;
            end
          endcase
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  assign high_ctrl = high_q;
  assign low_ctrl  = low_q;
  assign pwm_sync  = sync_q;

endmodule

// File: tb/tb_pwm_phase_gen.sv
// Directed bench for pwm_phase_gen: whole-period measurements of the
// high/low/sync pattern plus start, stop and reset sequences.
module tb_pwm_phase_gen;

  localparam int W   = 11;
  localparam int PER = 2048;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] duty;
  logic [1:0]   mode;
  logic         high_ctrl;
  logic         low_ctrl;
  logic         pwm_sync;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pwm_phase_gen #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .duty     (duty),
    .mode     (mode),
    .high_ctrl(high_ctrl),
    .low_ctrl (low_ctrl),
    .pwm_sync (pwm_sync)
  );

  // Shoot-through guard on every cycle of every test.
  always @(negedge clk) begin
    checks++;
    if ((high_ctrl & low_ctrl) !== 1'b0) begin
      fails++;
      $display("FAIL overlap t=%0t: high=%b low=%b, required not both 1", $time, high_ctrl, low_ctrl);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until pwm_sync is seen; n = steps taken, -1 when the budget expires.
  task automatic wait_sync(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (pwm_sync === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Observe one period starting at the current (sync) cycle. shape counts
  // cycles where high_ctrl deviates from "high for the first exp_high clocks"
  // or pwm_sync is not exactly at index 0. Optionally rewrites duty/mode at
  // index chg_at to exercise mid-period updates.
  task automatic measure(input int exp_high, input int chg_at,
                         input logic [W-1:0] nd, input logic [1:0] nm,
                         output int nh, output int nl, output int ns, output int shape);
    nh = 0; nl = 0; ns = 0; shape = 0;
    for (int i = 0; i < PER; i++) begin
      if (i > 0) step();
      if (high_ctrl === 1'b1) nh++;
      if (low_ctrl === 1'b1) nl++;
      if (pwm_sync === 1'b1) ns++;
      if (pwm_sync !== (i == 0)) shape++;
      if (high_ctrl !== (i < exp_high)) shape++;
      if (i == chg_at) begin
        duty = nd;
        mode = nm;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; duty = 11'd512; mode = 2'b01;
    repeat (3) step();
    checks++;
    if ({high_ctrl, low_ctrl, pwm_sync} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs: got %b, required 000", {high_ctrl, low_ctrl, pwm_sync});
    end
    rst = 1'b0;
    repeat (4) step();
    checks++;
    if ({high_ctrl, low_ctrl, pwm_sync} !== 3'b000) begin
      fails++;
      $display("FAIL idle_after_release: got %b, required 000", {high_ctrl, low_ctrl, pwm_sync});
    end
    $display("reset: outputs=%b", {high_ctrl, low_ctrl, pwm_sync});
  endtask

  task automatic test_drive();
    int n, nh, nl, ns, sh;
    en = 1'b1;
    wait_sync(6, n);
    checks++;
    if (n !== 2) begin
      fails++;
      $display("FAIL start_latency: sync after %0d clk, required 2", n);
    end
    measure(512, -1, 11'd512, 2'b01, nh, nl, ns, sh);
    $display("period drive512: high=%0d low=%0d sync=%0d shape=%0d", nh, nl, ns, sh);
    checks++;
    if (nh !== 512 || nl !== 1536 || ns !== 1 || sh !== 0) begin
      fails++;
      $display("FAIL drive512: got %0d/%0d/%0d/%0d, required 512/1536/1/0", nh, nl, ns, sh);
    end
  endtask

  task automatic test_duty_change();
    int n, nh, nl, ns, sh;
    wait_sync(2, n);
    checks++;
    if (n !== 1) begin
      fails++;
      $display("FAIL back_to_back_sync: sync after %0d clk, required 1", n);
    end
    measure(512, 1000, 11'd1500, 2'b01, nh, nl, ns, sh);
    $display("period duty_chg_cur: high=%0d low=%0d sync=%0d shape=%0d", nh, nl, ns, sh);
    checks++;
    if (nh !== 512 || nl !== 1536 || ns !== 1 || sh !== 0) begin
      fails++;
      $display("FAIL duty_chg_cur: got %0d/%0d/%0d/%0d, required 512/1536/1/0", nh, nl, ns, sh);
    end
    wait_sync(2, n);
    measure(1500, 100, 11'd0, 2'b01, nh, nl, ns, sh);
    $display("period duty_chg_next: high=%0d low=%0d sync=%0d shape=%0d", nh, nl, ns, sh);
    checks++;
    if (nh !== 1500 || nl !== 548 || ns !== 1 || sh !== 0) begin
      fails++;
      $display("FAIL duty_chg_next: got %0d/%0d/%0d/%0d, required 1500/548/1/0", nh, nl, ns, sh);
    end
  endtask

  task automatic test_duty_bounds();
    int n, nh, nl, ns, sh;
    for (int p = 0; p < 3; p++) begin
      wait_sync(2, n);
      measure(0, (p == 2) ? 50 : -1, 11'd2047, 2'b01, nh, nl, ns, sh);
      $display("period duty0 #%0d: high=%0d low=%0d sync=%0d shape=%0d", p, nh, nl, ns, sh);
      checks++;
      if (nh !== 0 || nl !== 2048 || ns !== 1 || sh !== 0) begin
        fails++;
        $display("FAIL duty0 #%0d: got %0d/%0d/%0d/%0d, required 0/2048/1/0", p, nh, nl, ns, sh);
      end
    end
    wait_sync(2, n);
    measure(2047, -1, 11'd2047, 2'b01, nh, nl, ns, sh);
    $display("period duty2047: high=%0d low=%0d sync=%0d shape=%0d", nh, nl, ns, sh);
    checks++;
    if (nh !== 2047 || nl !== 1 || ns !== 1 || sh !== 0) begin
      fails++;
      $display("FAIL duty2047: got %0d/%0d/%0d/%0d, required 2047/1/1/0", nh, nl, ns, sh);
    end
  endtask

  task automatic test_mode();
    int n, nh, nl, ns, sh;
    wait_sync(2, n);
    measure(2047, 100, 11'd2047, 2'b10, nh, nl, ns, sh);
    $display("period brake_pending: high=%0d low=%0d sync=%0d shape=%0d", nh, nl, ns, sh);
    checks++;
    if (nh !== 2047 || nl !== 1 || ns !== 1 || sh !== 0) begin
      fails++;
      $display("FAIL brake_pending: got %0d/%0d/%0d/%0d, required 2047/1/1/0", nh, nl, ns, sh);
    end
    wait_sync(2, n);
    measure(0, 100, 11'd2047, 2'b11, nh, nl, ns, sh);
    $display("period brake: high=%0d low=%0d sync=%0d shape=%0d", nh, nl, ns, sh);
    checks++;
    if (nh !== 0 || nl !== 2048 || ns !== 1 || sh !== 0) begin
      fails++;
      $display("FAIL brake: got %0d/%0d/%0d/%0d, required 0/2048/1/0", nh, nl, ns, sh);
    end
    wait_sync(2, n);
    measure(0, 100, 11'd512, 2'b01, nh, nl, ns, sh);
    $display("period coast11: high=%0d low=%0d sync=%0d shape=%0d", nh, nl, ns, sh);
    checks++;
    if (nh !== 0 || nl !== 0 || ns !== 1 || sh !== 0) begin
      fails++;
      $display("FAIL coast11: got %0d/%0d/%0d/%0d, required 0/0/1/0", nh, nl, ns, sh);
    end
  endtask

  task automatic test_stop_restart();
    int n, nh, nl, ns, sh;
    wait_sync(2, n);
    repeat (299) step();
    checks++;
    if ({high_ctrl, low_ctrl} !== 2'b10) begin
      fails++;
      $display("FAIL pre_stop: got %b, required 10", {high_ctrl, low_ctrl});
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({high_ctrl, low_ctrl, pwm_sync} !== 3'b000) begin
        fails++;
        $display("FAIL stopped clk%0d: got %b, required 000", i, {high_ctrl, low_ctrl, pwm_sync});
      end
    end
    en = 1'b1;
    step();
    checks++;
    if ({high_ctrl, low_ctrl, pwm_sync} !== 3'b000) begin
      fails++;
      $display("FAIL restart_edge: got %b, required 000", {high_ctrl, low_ctrl, pwm_sync});
    end
    step();
    checks++;
    if ({high_ctrl, low_ctrl, pwm_sync} !== 3'b101) begin
      fails++;
      $display("FAIL restart_sync: got %b, required 101", {high_ctrl, low_ctrl, pwm_sync});
    end
    measure(512, -1, 11'd512, 2'b01, nh, nl, ns, sh);
    $display("period restart: high=%0d low=%0d sync=%0d shape=%0d", nh, nl, ns, sh);
    checks++;
    if (nh !== 512 || nl !== 1536 || ns !== 1 || sh !== 0) begin
      fails++;
      $display("FAIL restart_period: got %0d/%0d/%0d/%0d, required 512/1536/1/0", nh, nl, ns, sh);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    wait_sync(2, n);
    repeat (50) step();
    duty = 11'd100;
    en = 1'b0;
    step();
    checks++;
    if ({high_ctrl, low_ctrl, pwm_sync} !== 3'b000) begin
      fails++;
      $display("FAIL toggle_coast: got %b, required 000", {high_ctrl, low_ctrl, pwm_sync});
    end
    en = 1'b1;
    step();
    checks++;
    if ({high_ctrl, low_ctrl, pwm_sync} !== 3'b000) begin
      fails++;
      $display("FAIL toggle_start: got %b, required 000", {high_ctrl, low_ctrl, pwm_sync});
    end
    step();
    checks++;
    if ({high_ctrl, low_ctrl, pwm_sync} !== 3'b101) begin
      fails++;
      $display("FAIL toggle_sync: got %b, required 101", {high_ctrl, low_ctrl, pwm_sync});
    end
    // New duty (100) must be in force: clock 100 of the fresh period is low.
    repeat (99) step();
    checks++;
    if ({high_ctrl, low_ctrl} !== 2'b10) begin
      fails++;
      $display("FAIL toggle_duty_last_high: got %b, required 10", {high_ctrl, low_ctrl});
    end
    step();
    checks++;
    if ({high_ctrl, low_ctrl} !== 2'b01) begin
      fails++;
      $display("FAIL toggle_duty_first_low: got %b, required 01", {high_ctrl, low_ctrl});
    end
    $display("toggle: fresh start with duty=100 observed");
    duty = 11'd512;
  endtask

  task automatic test_reset_mid();
    int n, nh, nl, ns, sh;
    wait_sync(2200, n);
    repeat (199) step();
    checks++;
    if ({high_ctrl, low_ctrl} !== 2'b10) begin
      fails++;
      $display("FAIL pre_reset: got %b, required 10", {high_ctrl, low_ctrl});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({high_ctrl, low_ctrl, pwm_sync} !== 3'b000) begin
      fails++;
      $display("FAIL async_reset: got %b, required 000", {high_ctrl, low_ctrl, pwm_sync});
    end
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++;
    if ({high_ctrl, low_ctrl, pwm_sync} !== 3'b000) begin
      fails++;
      $display("FAIL post_reset_start: got %b, required 000", {high_ctrl, low_ctrl, pwm_sync});
    end
    step();
    checks++;
    if ({high_ctrl, low_ctrl, pwm_sync} !== 3'b101) begin
      fails++;
      $display("FAIL post_reset_sync: got %b, required 101", {high_ctrl, low_ctrl, pwm_sync});
    end
    measure(512, -1, 11'd512, 2'b01, nh, nl, ns, sh);
    $display("period post_reset: high=%0d low=%0d sync=%0d shape=%0d", nh, nl, ns, sh);
    checks++;
    if (nh !== 512 || nl !== 1536 || ns !== 1 || sh !== 0) begin
      fails++;
      $display("FAIL post_reset_period: got %0d/%0d/%0d/%0d, required 512/1536/1/0", nh, nl, ns, sh);
    end
  endtask

  initial begin
    test_reset();
    test_drive();
    test_duty_change();
    test_duty_bounds();
    test_mode();
    test_stop_restart();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
